// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================
// Module   : keypad_pkg
// Purpose  : Shared states, constants and row decode for the keypad scanner.
// Revision : 1.0
// ============================================================
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DEBOUNCE   = 2'd1,
      PRESSED    = 2'd2,
      RELEASE_DB = 2'd3
   } state_t;

   localparam int         KEY_CODE_W             = 4;
   localparam logic [3:0] COL_PATTERN [0:3]      = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   localparam logic [3:0] ROWS_IDLE              = 4'b1111;

   // Lowest-indexed low row wins when several rows are down in one column.
   function automatic logic [1:0] row_index(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================
// Module   : key_event_fifo
// Purpose  : Small synchronous FIFO for key codes with full/empty/drop flags.
// Revision : 1.0
// ============================================================
module key_event_fifo
   import keypad_pkg::*;
#(
   parameter int WIDTH = KEY_CODE_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_drop
);

   localparam int               c_PTR_W   = $clog2(DEPTH);
   localparam logic [c_PTR_W:0] c_PTR_ONE = (c_PTR_W + 1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_PTR_W:0] r_wr_ptr;
   logic [c_PTR_W:0] r_rd_ptr;
   logic             w_pop;
   logic             w_write;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                    (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
   assign w_pop   = i_pop && !o_empty;
   assign w_write = i_push && (!o_full || w_pop);
   assign o_drop  = i_push && o_full && !w_pop;
   assign o_data  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_write) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_data;
            r_wr_ptr                     <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================
// Module   : keypad_scan_ctrl
// Purpose  : 4x4 keypad column scan, row debounce and key-event FIFO.
// Revision : 1.0
// ============================================================
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 20,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key_r,
   output logic [3:0] key_c,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_held,
   output logic       overflow
);

   localparam int                   c_DWELL_W    = $clog2(SCAN_DIV);
   localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(SCAN_DIV - 1);
   localparam logic [c_DWELL_W-1:0] c_DWELL_ONE  = c_DWELL_W'(1);
   localparam logic [7:0]           c_DB_TARGET  = 8'(DEBOUNCE_CNT);

   logic [1:0]            r_rst_sync;
   logic                  w_rst_n;
   logic [3:0]            r_row_meta;
   logic [3:0]            r_rows;
   logic [c_DWELL_W-1:0]  r_dwell;
   logic                  w_tick;

   state_t                r_state, w_state_nxt;
   logic [1:0]            r_col, w_col_nxt;
   logic [3:0]            r_code, w_code_nxt;
   logic [7:0]            r_cnt, w_cnt_nxt, w_cnt_inc;
   logic                  r_held, w_held_nxt;
   logic                  w_push;
   logic                  w_rows_active;
   logic [3:0]            w_sample_code;

   logic                  w_fifo_empty;
   logic                  w_fifo_drop;
   logic                  r_overflow;

   // Reset asserts immediately but releases two clocks later, in step with clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_row_meta <= ROWS_IDLE;
         r_rows     <= ROWS_IDLE;
         r_dwell    <= '0;
      end else begin
         r_row_meta <= key_r;
         r_rows     <= r_row_meta;
         r_dwell    <= w_tick ? '0 : r_dwell + c_DWELL_ONE;
      end
   end

   assign w_tick        = (r_dwell == c_DWELL_LAST);
   assign w_rows_active = (r_rows != ROWS_IDLE);
   assign w_sample_code = {row_index(r_rows), r_col};
   assign w_cnt_inc     = r_cnt + 8'd1;

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= IDLE;
         r_col   <= 2'd0;
         r_code  <= 4'd0;
         r_cnt   <= 8'd0;
         r_held  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_col   <= w_col_nxt;
         r_code  <= w_code_nxt;
         r_cnt   <= w_cnt_nxt;
         r_held  <= w_held_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_col_nxt   = r_col;
      w_code_nxt  = r_code;
      w_cnt_nxt   = r_cnt;
      w_held_nxt  = r_held;
      w_push      = 1'b0;
      if (w_tick) begin
         unique case (r_state)
            IDLE: begin
               if (w_rows_active) begin
                  w_code_nxt = w_sample_code;
                  w_cnt_nxt  = 8'd1;
                  if (c_DB_TARGET == 8'd1) begin
                     w_push      = 1'b1;
                     w_held_nxt  = 1'b1;
                     w_state_nxt = PRESSED;
                  end else begin
                     w_state_nxt = DEBOUNCE;
                  end
               end else begin
                  w_col_nxt = r_col + 2'd1;
               end
            end
            DEBOUNCE: begin
               // Column is frozen here, so a code match means the same row is still low.
               if (w_rows_active && (w_sample_code == r_code)) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == c_DB_TARGET) begin
                     w_push      = 1'b1;
                     w_held_nxt  = 1'b1;
                     w_state_nxt = PRESSED;
                  end
               end else begin
                  w_cnt_nxt   = 8'd0;
                  w_col_nxt   = r_col + 2'd1;
                  w_state_nxt = IDLE;
               end
            end
            PRESSED: begin
               if (!w_rows_active) begin
                  w_cnt_nxt = 8'd1;
                  if (c_DB_TARGET == 8'd1) begin
                     w_cnt_nxt   = 8'd0;
                     w_held_nxt  = 1'b0;
                     w_col_nxt   = r_col + 2'd1;
                     w_state_nxt = IDLE;
                  end else begin
                     w_state_nxt = RELEASE_DB;
                  end
               end
            end
            RELEASE_DB: begin
               if (!w_rows_active) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == c_DB_TARGET) begin
                     w_cnt_nxt   = 8'd0;
                     w_held_nxt  = 1'b0;
                     w_col_nxt   = r_col + 2'd1;
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = PRESSED;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   key_event_fifo #(
      .WIDTH (KEY_CODE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (w_rst_n),
      .i_push  (w_push),
      .i_data  (r_code),
      .i_pop   (key_ready),
      .o_data  (key_code),
      .o_full  (),
      .o_empty (w_fifo_empty),
      .o_drop  (w_fifo_drop)
   );

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) r_overflow <= 1'b0;
      else          r_overflow <= r_overflow | w_fifo_drop;
   end

   assign key_c     = COL_PATTERN[r_col];
   assign key_valid = !w_fifo_empty;
   assign key_held  = r_held;
   assign overflow  = r_overflow;

endmodule
`default_nettype wire
